// File: rtl/fam_mac_array.sv
// ---------------------------------------------------------------------------
// fam_mac_array : valid/ready multiply-accumulate lane array (sum/max rows).
// Optional macro FAM_SAT_EN: saturating product truncation and sum. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fam_mac_array #(
   parameter int WL   = 32,
   parameter int NUM  = 128,
   parameter int FRAC = 16,
   parameter int CW   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WL-1:0]     in_value,
   input  logic [WL*NUM-1:0] in_feature,
   input  logic              in_last,
   input  logic              in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WL*NUM-1:0] out_result,
   output logic [CW-1:0]     out_count
);

   logic          s1_valid_q, s1_valid_d;
   logic          s1_last_q, s1_last_d;
   logic          s1_mode_q, s1_mode_d;
   logic          s1_first_q, s1_first_d;
   logic          first_q, first_d;
   logic          held_mode_q, held_mode_d;
   logic          out_valid_q, out_valid_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] out_count_q, out_count_d;
   logic [WL-1:0] s1_prod_q [NUM];
   logic [WL-1:0] s1_prod_d [NUM];
   logic [WL-1:0] acc_q [NUM];
   logic [WL-1:0] acc_d [NUM];
   logic [WL-1:0] out_res_q [NUM];
   logic [WL-1:0] out_res_d [NUM];

   logic [WL-1:0] prod_w [NUM];
   logic [WL-1:0] upd_w [NUM];
   logic          stall_w;
   logic          accept_w;
   logic          s2_go_w;
   logic          row_mode_w;
   logic [CW-1:0] cnt_inc_w;

   for (genvar i = 0; i < NUM; i++) begin : g_lane
      logic signed [2*WL-1:0] full;
      logic signed [WL-1:0]   acc_s;
      logic signed [WL-1:0]   p_s;
      logic [WL-1:0]          sum;
      logic [WL-1:0]          max;

      assign full  = $signed(in_value) * $signed(in_feature[i*WL +: WL]);
      assign acc_s = $signed(acc_q[i]);
      assign p_s   = $signed(s1_prod_q[i]);
      assign max   = (acc_s > p_s) ? acc_q[i] : s1_prod_q[i];

`ifdef FAM_SAT_EN
      localparam logic signed [2*WL-1:0] c_max_wide = {{(WL+1){1'b0}}, {(WL-1){1'b1}}};
      localparam logic signed [2*WL-1:0] c_min_wide = {{(WL+1){1'b1}}, {(WL-1){1'b0}}};
      logic signed [2*WL-1:0] shifted;
      logic [WL:0]            sum_wide;

      assign shifted   = full >>> FRAC;
      assign prod_w[i] = (shifted > c_max_wide) ? {1'b0, {(WL-1){1'b1}}} :
                         (shifted < c_min_wide) ? {1'b1, {(WL-1){1'b0}}} :
                         shifted[WL-1:0];
      assign sum_wide  = {acc_q[i][WL-1], acc_q[i]} + {s1_prod_q[i][WL-1], s1_prod_q[i]};
      // Overflow shows as disagreement between the two top bits; clamp toward the true sign.
      assign sum       = (sum_wide[WL] != sum_wide[WL-1]) ?
                         {sum_wide[WL], {(WL-1){~sum_wide[WL]}}} : sum_wide[WL-1:0];
`else
      assign prod_w[i] = WL'(full >>> FRAC);
      assign sum       = acc_q[i] + s1_prod_q[i];
`endif

      assign upd_w[i] = s1_first_q ? s1_prod_q[i] : (s1_mode_q ? max : sum);
      assign out_result[i*WL +: WL] = out_res_q[i];
   end

   assign in_ready  = ~stall_w;
   assign out_valid = out_valid_q;
   assign out_count = out_count_q;

   always_comb begin
      stall_w     = s1_valid_q & s1_last_q & out_valid_q & ~out_ready;
      accept_w    = in_valid & ~stall_w;
      s2_go_w     = s1_valid_q & ~stall_w;
      row_mode_w  = first_q ? in_mode : held_mode_q;
      cnt_inc_w   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

      s1_valid_d  = s1_valid_q;
      s1_last_d   = s1_last_q;
      s1_mode_d   = s1_mode_q;
      s1_first_d  = s1_first_q;
      first_d     = first_q;
      held_mode_d = held_mode_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;
      out_count_d = out_count_q;
      s1_prod_d   = s1_prod_q;
      acc_d       = acc_q;
      out_res_d   = out_res_q;

      // The first-beat flag follows accepted beats so a new row can enter
      // S1 while the previous row's last beat is still being accumulated.
      if (!stall_w) begin
         s1_valid_d = accept_w;
         if (accept_w) begin
            s1_prod_d   = prod_w;
            s1_last_d   = in_last;
            s1_mode_d   = row_mode_w;
            s1_first_d  = first_q;
            held_mode_d = row_mode_w;
            first_d     = in_last;
         end
      end

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (s2_go_w) begin
         cnt_d = cnt_inc_w;
         acc_d = upd_w;
         if (s1_last_q) begin
            out_res_d   = upd_w;
            out_count_d = cnt_inc_w;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            for (int i = 0; i < NUM; i++) begin
               acc_d[i] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_mode_q   <= 1'b0;
         s1_first_q  <= 1'b0;
         first_q     <= 1'b1;
         held_mode_q <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         out_count_q <= '0;
         for (int i = 0; i < NUM; i++) begin
            s1_prod_q[i] <= '0;
            acc_q[i]     <= '0;
            out_res_q[i] <= '0;
         end
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         s1_mode_q   <= s1_mode_d;
         s1_first_q  <= s1_first_d;
         first_q     <= first_d;
         held_mode_q <= held_mode_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         out_count_q <= out_count_d;
         s1_prod_q   <= s1_prod_d;
         acc_q       <= acc_d;
         out_res_q   <= out_res_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fam_mac_array.sv
// ---------------------------------------------------------------------------
// tb_fam_mac_array : scoreboard bench, rows modelled from their list of beats.
// Honours FAM_SAT_EN in the reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fam_mac_array;
   localparam int WL   = 16;
   localparam int NUM  = 4;
   localparam int FRAC = 8;
   localparam int CW   = 4;
   localparam longint MAXV = (longint'(1) <<< (WL-1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (WL-1));

   typedef struct {
      logic [WL*NUM-1:0] res;
      logic [CW-1:0]     cnt;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WL-1:0]     in_value;
   logic [WL*NUM-1:0] in_feature;
   logic              in_last;
   logic              in_mode;
   logic              out_valid;
   logic              out_ready;
   logic [WL*NUM-1:0] out_result;
   logic [CW-1:0]     out_count;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;   // 0 always ready, 1 random, 2 driven by main thread

   exp_t              exp_q[$];
   logic [WL-1:0]     rv_q[$];
   logic [WL*NUM-1:0] rf_q[$];
   bit                row_first = 1'b1;
   bit                row_mode  = 1'b0;

   fam_mac_array #(.WL(WL), .NUM(NUM), .FRAC(FRAC), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
      .in_feature(in_feature), .in_last(in_last), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_count(out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [WL-1:0] m_prod(input logic [WL-1:0] v, input logic [WL-1:0] f);
      longint p;
      p = longint'($signed(v)) * longint'($signed(f));
      p = p >>> FRAC;
`ifdef FAM_SAT_EN
      if (p > MAXV) p = MAXV;
      else if (p < MINV) p = MINV;
`endif
      return p[WL-1:0];
   endfunction

   function automatic logic [WL-1:0] m_add(input logic [WL-1:0] a, input logic [WL-1:0] b);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
`ifdef FAM_SAT_EN
      if (s > MAXV) s = MAXV;
      else if (s < MINV) s = MINV;
`endif
      return s[WL-1:0];
   endfunction

   // Expected row from the complete list of its beats.
   function automatic exp_t row_expect();
      exp_t e;
      for (int l = 0; l < NUM; l++) begin
         logic [WL-1:0] acc;
         logic [WL-1:0] p;
         acc = m_prod(rv_q[0], rf_q[0][l*WL +: WL]);
         for (int k = 1; k < rv_q.size(); k++) begin
            p = m_prod(rv_q[k], rf_q[k][l*WL +: WL]);
            if (row_mode) acc = ($signed(p) > $signed(acc)) ? p : acc;
            else          acc = m_add(acc, p);
         end
         e.res[l*WL +: WL] = acc;
      end
      e.cnt = (rv_q.size() > (2**CW - 1)) ? CW'(2**CW - 1) : CW'(rv_q.size());
      return e;
   endfunction

   function automatic void model_accept(input logic [WL-1:0] v, input logic [WL*NUM-1:0] f,
                                        input bit last, input bit mode);
      if (row_first) row_mode = mode;
      rv_q.push_back(v);
      rf_q.push_back(f);
      if (last) begin
         exp_q.push_back(row_expect());
         rv_q.delete();
         rf_q.delete();
         row_first = 1'b1;
      end else begin
         row_first = 1'b0;
      end
   endfunction

   // Entered and left at posedge+1.
   task automatic send_beat(input logic [WL-1:0] v, input logic [WL*NUM-1:0] f,
                            input bit last, input bit mode);
      int guard = 0;
      bit ok = 1'b0;
      in_valid = 1'b1; in_value = v; in_feature = f; in_last = last; in_mode = mode;
      while (!ok && guard < 200) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else guard++;
      end
      if (ok) begin
         model_accept(v, f, last, mode);
      end else begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=no_accept required=accept");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL drain_timeout actual=pending%0d required=0", exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [WL*NUM-1:0] vec4(input int a, input int b, input int c, input int d);
      logic [WL*NUM-1:0] r;
      r = {WL'(d), WL'(c), WL'(b), WL'(a)};
      return r;
   endfunction

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rdy_mode == 0) out_ready = 1'b1;
         else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pop and compare on each output handshake, check hold stability.
   initial begin
      bit hold = 1'b0;
      logic [WL*NUM-1:0] hold_res;
      logic [CW-1:0] hold_cnt;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               chk("hold_valid", 64'(out_valid), 64'(1));
               chk("hold_result", out_result, hold_res);
               chk("hold_count", 64'(out_count), 64'(hold_cnt));
            end
            if (out_valid && out_ready) begin
               hold = 1'b0;
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_row actual=%h required=none", out_result);
               end else begin
                  e = exp_q.pop_front();
                  chk("row_result", out_result, e.res);
                  chk("row_count", 64'(out_count), 64'(e.cnt));
               end
            end else if (out_valid) begin
               hold = 1'b1; hold_res = out_result; hold_cnt = out_count;
            end else begin
               hold = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_value = '0; in_feature = '0;
      in_last = 1'b0; in_mode = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_out_result", out_result, 64'(0));
      chk("reset_out_count", 64'(out_count), 64'(0));
      chk("reset_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);

      // Sum row: values 1,2,3 (FRAC=8 scaled), features (1,2,3,4); latency check.
      send_beat(16'h0100, vec4(1, 2, 3, 4), 1'b0, 1'b0);
      send_beat(16'h0200, vec4(1, 2, 3, 4), 1'b0, 1'b1);
      send_beat(16'h0300, vec4(1, 2, 3, 4), 1'b1, 1'b1);
      @(negedge clk);
      chk("latency_cycle1", 64'(out_valid), 64'(0));
      @(negedge clk);
      chk("latency_cycle2", 64'(out_valid), 64'(1));
      chk("sum_row_direct", out_result, vec4(6, 12, 18, 24));
      @(posedge clk); #1;
      wait_drain();

      // Max row; the second beat's mode must be ignored.
      send_beat(16'h0100, vec4(5, -3, 0, 7), 1'b0, 1'b1);
      send_beat(16'h0100, vec4(2, 4, -1, 9), 1'b1, 1'b0);
      wait_drain();

      // 1.5 * 2.0 = 3.0 in Q8.
      send_beat(16'h0180, vec4(16'h0200, 16'h0200, 16'h0200, 16'h0200), 1'b1, 1'b0);
      wait_drain();

      // Overflowing sum: wraps to 0xC000, or clamps to 0x7FFF with FAM_SAT_EN.
      send_beat(16'h0100, vec4(16'h6000, 16'h6000, 16'h6000, 16'h6000), 1'b0, 1'b0);
      send_beat(16'h0100, vec4(16'h6000, 16'h6000, 16'h6000, 16'h6000), 1'b1, 1'b0);
      wait_drain();

      // Back-to-back single-beat rows against a blocked output.
      rdy_mode = 2; out_ready = 1'b0;
      send_beat(16'($urandom), {$urandom, $urandom}, 1'b1, 1'b0);
      send_beat(16'($urandom), {$urandom, $urandom}, 1'b1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(in_ready), 64'(0));
         chk("stall_out_valid", 64'(out_valid), 64'(1));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("reload_no_gap", 64'(out_valid), 64'(1));
      chk("reload_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      rdy_mode = 0;
      wait_drain();

      // Reset mid-row discards the partial row.
      send_beat(16'($urandom), {$urandom, $urandom}, 1'b0, 1'b1);
      send_beat(16'($urandom), {$urandom, $urandom}, 1'b0, 1'b1);
      rst_n = 1'b0;
      rv_q.delete(); rf_q.delete(); row_first = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midreset_out_valid", 64'(out_valid), 64'(0));
      chk("midreset_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      send_beat(16'h0100, vec4(1, 1, 1, 1), 1'b1, 1'b0);
      wait_drain();

      // Long row saturates the edge counter.
      for (int k = 0; k < 20; k++) begin
         send_beat(16'($urandom_range(0, 16'h0200)), {$urandom, $urandom}, k == 19, 1'b0);
      end
      wait_drain();

      // Randomised traffic with random backpressure and idle gaps.
      rdy_mode = 1;
      for (int k = 0; k < 300; k++) begin
         logic [WL-1:0] v;
         v = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h0300));
         send_beat(v, {$urandom, $urandom}, ($urandom_range(0, 3) == 0) || k == 299,
                   1'($urandom_range(0, 1)));
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      rdy_mode = 0;
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
